// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: walks the program counter, requests instruction
// words from program memory, holds the fetched word in ir until the decoder
// accepts it, and handles branch/jump redirects via pc_load.
// Optional build macro IFU_STALL_CNT_EN adds a 16-bit saturating counter of
// cycles where a held instruction waits on the decoder (output stall_cnt).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | just out of reset, no request yet
// FETCH | mem_req high, waiting for mem_ack for the word at pc
// HOLD  | ir holds an unconsumed instruction, waiting for ir_ready
module instr_fetch_unit #(
  parameter int INSTR_WIDTH = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int IMM_WIDTH   = 6,
  parameter int CS_BIT      = 11,
  parameter int RESET_PC    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_ack,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  input  logic                   pc_load,
  input  logic [ADDR_WIDTH-1:0]  pc_load_val,
  output logic [INSTR_WIDTH-1:0] ir,
  output logic                   ir_valid,
  input  logic                   ir_ready,
  output logic [IMM_WIDTH-1:0]   const_field,
  output logic                   const_signed,
`ifdef IFU_STALL_CNT_EN
  output logic [15:0]            stall_cnt,
`endif
  output logic [ADDR_WIDTH-1:0]  pc_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [ADDR_WIDTH-1:0]  pc;
  logic                   fetch_done;

  // A fetch only completes when no redirect competes with it; a redirect
  // throws the returned word away.
  assign fetch_done = (state == FETCH) && mem_ack && !pc_load;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a redirect always lands in FETCH
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH: begin
        if (pc_load)      state_nxt = FETCH;
        else if (mem_ack) state_nxt = HOLD;
      end
      HOLD: begin
        if (pc_load || ir_ready) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM-decoded outputs
  always_comb begin
    mem_req  = 1'b0;
    ir_valid = 1'b0;
    case (state)
      FETCH:   mem_req  = 1'b1;
      HOLD:    ir_valid = 1'b1;
      default: ;
    endcase
  end

  // Program counter: redirect wins over the post-fetch increment
  always_ff @(posedge clk) begin
    if (rst)
      pc <= ADDR_WIDTH'(RESET_PC);
    else if (pc_load)
      pc <= pc_load_val;
    else if (fetch_done)
      pc <= pc + ADDR_WIDTH'(1);
  end

  // Instruction register: only captures a completed fetch, otherwise holds
  always_ff @(posedge clk) begin
    if (rst)
      ir <= '0;
    else if (fetch_done)
      ir <= mem_rdata;
  end

`ifdef IFU_STALL_CNT_EN
  // Decoder back-pressure counter, saturating, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if ((state == HOLD) && !ir_ready && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

  assign mem_addr     = pc;
  assign pc_out       = pc;
  assign const_field  = ir[IMM_WIDTH-1:0];
  assign const_signed = ir[CS_BIT];

endmodule
